// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave model: word-addressed backing store with
// programmable wait states, HSIZE byte lanes and two-cycle ERROR.
//
// Ports:
//   hclk, hreset      clock, async active-high reset
//   hsel, haddr       slave select, byte address (offset from base)
//   htrans, hsize     transfer type, size (2^hsize bytes)
//   hwrite, hwdata    direction, write data (data phase)
//   hready            bus-level ready from the mux
//   hreadyout, hresp  this slave's ready and response
//   hrdata            read data, valid in the final read data-phase cycle
module ahb_mem_slave #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic          hwrite,
    input  logic [DW-1:0] hwdata,
    input  logic          hready,
    output logic          hreadyout,
    output logic          hresp,
    output logic [DW-1:0] hrdata
);

    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = LB + IW;
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH * NB);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          state, nxt;
    logic [3:0]      cnt, cnt_n;
    logic            act, act_n;
    logic [LW-1:0]   a_addr;
    logic [2:0]      a_size;
    logic            a_write;

    logic            hit;
    logic            accept;
    logic            err;
    logic            final_cyc;
    logic [IW-1:0]   word;
    logic [LB-1:0]   off;
    logic [NB-1:0]   be;

    logic [DW-1:0]   mem [DEPTH];

    // htrans[0] only separates NONSEQ/SEQ, irrelevant to this slave
    logic            unused_trans;
    assign unused_trans = htrans[0];

    always_comb begin
        hit    = (state == ST_IDLE) || (state == ST_ERR2);
        accept = hsel & hready & htrans[1] & hit;
        err    = ({1'b0, haddr} >= LIMIT)
               | (hsize > 3'(LB))
               | (|(haddr & ~({AW{1'b1}} << hsize)));
    end

    // act marks an OKAY data phase; its final cycle is act in ST_IDLE
    always_comb begin
        nxt       = state;
        cnt_n     = cnt;
        act_n     = act;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        unique case (state)
            ST_IDLE: ;
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (cnt == 4'd0) nxt = ST_IDLE;
                else             cnt_n = cnt - 4'd1;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                nxt       = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = 1'b1;
                nxt   = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
        if (hit) begin
            act_n = 1'b0;
            if (accept) begin
                if (err) begin
                    nxt = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    nxt   = ST_WAIT;
                    cnt_n = 4'(WAIT_STATES) - 4'd1;
                    act_n = 1'b1;
                end else begin
                    nxt   = ST_IDLE;
                    act_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            act     <= 1'b0;
            a_addr  <= '0;
            a_size  <= '0;
            a_write <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_n;
            act   <= act_n;
            if (accept) begin
                a_addr  <= haddr[LW-1:0];
                a_size  <= hsize;
                a_write <= hwrite;
            end
        end
    end

    assign final_cyc = act && (state == ST_IDLE);
    assign word      = a_addr[LW-1:LB];
    assign off       = a_addr[LB-1:0];

    always_comb begin
        int nbytes;
        nbytes = 32'd1 << a_size;
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= int'(off)) && (i < int'(off) + nbytes);
        end
    end

    // No reset: memory contents survive hreset; the async clear of
    // act is what aborts a pending write.
    always_ff @(posedge hclk) begin
        if (final_cyc && a_write) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[word][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    assign hrdata = (final_cyc && !a_write) ? mem[word] : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: three instances (DW32/WS0,
// DW32/WS3, DW64/WS0) sharing one address/data bus.
module tb_ahb_mem_slave;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic [2:0]  sel = '0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hsize = '0;
    logic        hwrite = 1'b0;
    logic [63:0] hwdata = '0;
    logic        hovr = 1'b0;
    logic        hforce = 1'b1;

    logic        ro0, ro1, ro2;
    logic        rs0, rs1, rs2;
    logic [31:0] rd0, rd1;
    logic [63:0] rd2;
    logic        hr0, hr1, hr2;

    int checks = 0;
    int fails  = 0;

    always #5 hclk = ~hclk;

    assign hr0 = hovr ? hforce : ro0;
    assign hr1 = hovr ? hforce : ro1;
    assign hr2 = hovr ? hforce : ro2;

    ahb_mem_slave #(.DW(32), .AW(32), .DEPTH(1024), .WAIT_STATES(0)) u0 (
        .hclk(hclk), .hreset(hreset), .hsel(sel[0]), .haddr(haddr),
        .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
        .hwdata(hwdata[31:0]), .hready(hr0), .hreadyout(ro0),
        .hresp(rs0), .hrdata(rd0));

    ahb_mem_slave #(.DW(32), .AW(32), .DEPTH(1024), .WAIT_STATES(3)) u1 (
        .hclk(hclk), .hreset(hreset), .hsel(sel[1]), .haddr(haddr),
        .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
        .hwdata(hwdata[31:0]), .hready(hr1), .hreadyout(ro1),
        .hresp(rs1), .hrdata(rd1));

    ahb_mem_slave #(.DW(64), .AW(32), .DEPTH(512), .WAIT_STATES(0)) u2 (
        .hclk(hclk), .hreset(hreset), .hsel(sel[2]), .haddr(haddr),
        .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
        .hwdata(hwdata), .hready(hr2), .hreadyout(ro2),
        .hresp(rs2), .hrdata(rd2));

    function automatic logic ro(input int k);
        return (k == 0) ? ro0 : (k == 1) ? ro1 : ro2;
    endfunction

    function automatic logic rs(input int k);
        return (k == 0) ? rs0 : (k == 1) ? rs1 : rs2;
    endfunction

    function automatic logic [63:0] rd(input int k);
        return (k == 0) ? {32'b0, rd0} : (k == 1) ? {32'b0, rd1} : rd2;
    endfunction

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // One isolated transfer; returns final-cycle data/resp, the resp seen
    // in the first data-phase cycle, and the number of hreadyout-low cycles.
    task automatic xfer(input int k, input logic [31:0] a,
                        input logic [2:0] sz, input logic wr,
                        input logic [63:0] wd, output logic [63:0] rdat,
                        output logic r1, output logic rf, output int low);
        sel = '0;
        sel[k] = 1'b1;
        haddr = a;
        hsize = sz;
        hwrite = wr;
        htrans = 2'b10;
        step();
        sel = '0;
        htrans = 2'b00;
        hwdata = wd;
        low = 0;
        r1 = rs(k);
        while (!ro(k) && low < 40) begin
            low++;
            step();
        end
        if (low >= 40) begin
            checks++;
            fails++;
            $display("FAIL xfer_timeout k=%0d addr=%h: hreadyout stuck low", k, a);
        end
        rdat = rd(k);
        rf = rs(k);
        step();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge hclk);
        #1;
        checks++;
        if ({ro0, ro1, ro2} !== 3'b111) begin
            fails++;
            $display("FAIL reset_hreadyout: got %b want 111", {ro0, ro1, ro2});
        end
        checks++;
        if ({rs0, rs1, rs2} !== 3'b000) begin
            fails++;
            $display("FAIL reset_hresp: got %b want 000", {rs0, rs1, rs2});
        end
        checks++;
        if ({rd0, rd1, rd2} !== 128'd0) begin
            fails++;
            $display("FAIL reset_hrdata: got %h %h %h want 0", rd0, rd1, rd2);
        end
        hreset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [63:0] d;
        logic r1, rf;
        int low;
        xfer(0, 32'h10, 3'd2, 1'b1, 64'hDEADBEEF, d, r1, rf, low);
        checks++;
        if (low !== 0 || rf !== 1'b0) begin
            fails++;
            $display("FAIL basic_write: got low=%0d resp=%b want 0/0", low, rf);
        end
        xfer(0, 32'h10, 3'd2, 1'b0, 64'h0, d, r1, rf, low);
        checks++;
        if (d !== 64'hDEADBEEF || low !== 0 || rf !== 1'b0) begin
            fails++;
            $display("FAIL basic_read: got %h low=%0d resp=%b want deadbeef/0/0",
                     d, low, rf);
        end
    endtask

    task automatic test_lanes();
        logic [63:0] d;
        logic r1, rf;
        int low;
        xfer(0, 32'h10, 3'd2, 1'b1, 64'h11223344, d, r1, rf, low);
        xfer(0, 32'h13, 3'd0, 1'b1, 64'hAA000000, d, r1, rf, low);
        xfer(0, 32'h10, 3'd2, 1'b0, 64'h0, d, r1, rf, low);
        checks++;
        if (d !== 64'hAA223344) begin
            fails++;
            $display("FAIL byte_lane: got %h want aa223344", d);
        end
        xfer(0, 32'h12, 3'd1, 1'b1, 64'h55550000, d, r1, rf, low);
        xfer(0, 32'h10, 3'd2, 1'b0, 64'h0, d, r1, rf, low);
        checks++;
        if (d !== 64'h55553344) begin
            fails++;
            $display("FAIL half_lane: got %h want 55553344", d);
        end
    endtask

    task automatic test_errors();
        logic [63:0] d;
        logic r1, rf;
        int low;
        xfer(0, 32'h0, 3'd2, 1'b1, 64'h01020304, d, r1, rf, low);
        xfer(0, 32'h1000, 3'd2, 1'b0, 64'h0, d, r1, rf, low);
        checks++;
        if (r1 !== 1'b1 || low !== 1 || rf !== 1'b1 || d !== 64'd0) begin
            fails++;
            $display("FAIL err_range: got r1=%b low=%0d rf=%b d=%h want 1/1/1/0",
                     r1, low, rf, d);
        end
        xfer(0, 32'h1, 3'd1, 1'b1, 64'hFFFFFFFF, d, r1, rf, low);
        checks++;
        if (r1 !== 1'b1 || low !== 1 || rf !== 1'b1) begin
            fails++;
            $display("FAIL err_align: got r1=%b low=%0d rf=%b want 1/1/1",
                     r1, low, rf);
        end
        xfer(0, 32'h0, 3'd3, 1'b1, 64'hFFFFFFFF, d, r1, rf, low);
        checks++;
        if (r1 !== 1'b1 || low !== 1 || rf !== 1'b1) begin
            fails++;
            $display("FAIL err_size: got r1=%b low=%0d rf=%b want 1/1/1",
                     r1, low, rf);
        end
        xfer(0, 32'h0, 3'd2, 1'b0, 64'h0, d, r1, rf, low);
        checks++;
        if (d !== 64'h01020304 || rf !== 1'b0) begin
            fails++;
            $display("FAIL err_nowrite: got %h resp=%b want 01020304/0", d, rf);
        end
    endtask

    task automatic test_wait();
        logic [63:0] d;
        logic r1, rf;
        int low;
        xfer(1, 32'h20, 3'd2, 1'b1, 64'h12345678, d, r1, rf, low);
        checks++;
        if (low !== 3 || r1 !== 1'b0 || rf !== 1'b0) begin
            fails++;
            $display("FAIL wait_write: got low=%0d r1=%b rf=%b want 3/0/0",
                     low, r1, rf);
        end
        xfer(1, 32'h20, 3'd2, 1'b0, 64'h0, d, r1, rf, low);
        checks++;
        if (low !== 3 || d !== 64'h12345678 || rf !== 1'b0) begin
            fails++;
            $display("FAIL wait_read: got low=%0d d=%h rf=%b want 3/12345678/0",
                     low, d, rf);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        logic r1, rf;
        int low;
        int cyc;
        int nxt;
        int done;
        logic [31:0] want;
        for (int i = 0; i < 4; i++) begin
            xfer(1, 32'h40 + 32'(4 * i), 3'd2, 1'b1,
                 64'hA0000000 + 64'(i), d, r1, rf, low);
        end
        sel = 3'b010;
        haddr = 32'h40;
        hsize = 3'd2;
        hwrite = 1'b0;
        htrans = 2'b10;
        cyc = 0;
        nxt = 1;
        done = 0;
        while (done < 4 && cyc < 100) begin
            step();
            cyc++;
            if (ro1) begin
                want = 32'hA0000000 + 32'(done);
                checks++;
                if (rd1 !== want) begin
                    fails++;
                    $display("FAIL b2b_data%0d: got %h want %h", done, rd1, want);
                end
                done++;
                if (nxt < 4) begin
                    haddr = 32'h40 + 32'(4 * nxt);
                    htrans = 2'b11;
                    nxt++;
                end else begin
                    sel = '0;
                    htrans = 2'b00;
                end
            end
        end
        checks++;
        if (cyc !== 16 || done !== 4) begin
            fails++;
            $display("FAIL b2b_cycles: got %0d cycles %0d done want 16/4", cyc, done);
        end
        sel = '0;
        htrans = 2'b00;
        step();

        // write immediately followed by read of the same word
        sel = 3'b001;
        haddr = 32'h30;
        hsize = 3'd2;
        hwrite = 1'b1;
        htrans = 2'b10;
        step();
        checks++;
        if (ro0 !== 1'b1) begin
            fails++;
            $display("FAIL raw_wready: got %b want 1", ro0);
        end
        hwdata = 64'hCAFEF00D;
        hwrite = 1'b0;
        step();
        checks++;
        if (ro0 !== 1'b1 || rd0 !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL raw_read: got ro=%b d=%h want 1/cafef00d", ro0, rd0);
        end
        sel = '0;
        htrans = 2'b00;
        step();
    endtask

    task automatic test_wide();
        logic [63:0] d;
        logic r1, rf;
        int low;
        xfer(2, 32'h8, 3'd3, 1'b1, 64'h0123456789ABCDEF, d, r1, rf, low);
        checks++;
        if (low !== 0 || rf !== 1'b0) begin
            fails++;
            $display("FAIL wide_write: got low=%0d rf=%b want 0/0", low, rf);
        end
        xfer(2, 32'h8, 3'd3, 1'b0, 64'h0, d, r1, rf, low);
        checks++;
        if (d !== 64'h0123456789ABCDEF || rf !== 1'b0) begin
            fails++;
            $display("FAIL wide_read: got %h rf=%b want 0123456789abcdef/0", d, rf);
        end
        hovr = 1'b1;
        hforce = 1'b0;
        sel = 3'b100;
        haddr = 32'h8;
        hsize = 3'd3;
        hwrite = 1'b0;
        htrans = 2'b10;
        step();
        hovr = 1'b0;
        hforce = 1'b1;
        sel = '0;
        htrans = 2'b00;
        checks++;
        if (ro2 !== 1'b1 || rs2 !== 1'b0 || rd2 !== 64'd0) begin
            fails++;
            $display("FAIL hready_low: got ro=%b rs=%b d=%h want 1/0/0",
                     ro2, rs2, rd2);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        logic r1, rf;
        int low;
        xfer(1, 32'h50, 3'd2, 1'b1, 64'h11111111, d, r1, rf, low);
        sel = 3'b010;
        haddr = 32'h50;
        hsize = 3'd2;
        hwrite = 1'b1;
        htrans = 2'b10;
        step();
        sel = '0;
        htrans = 2'b00;
        hwdata = 64'h22222222;
        checks++;
        if (ro1 !== 1'b0) begin
            fails++;
            $display("FAIL mid_wait: got %b want 0", ro1);
        end
        step();
        hreset = 1'b1;
        #1;
        checks++;
        if (ro1 !== 1'b1 || rs1 !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got ro=%b rs=%b want 1/0", ro1, rs1);
        end
        repeat (2) @(posedge hclk);
        #1;
        hreset = 1'b0;
        step();
        xfer(1, 32'h50, 3'd2, 1'b0, 64'h0, d, r1, rf, low);
        checks++;
        if (d !== 64'h11111111 || low !== 3) begin
            fails++;
            $display("FAIL mid_old: got %h low=%0d want 11111111/3", d, low);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lanes();
        test_errors();
        test_wait();
        test_back_to_back();
        test_wide();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
